// File: rtl/adder_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adder_arb_pkg                                                              |
// | Shared widths, FSM encoding and constants for the adder arbiter.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package adder_arb_pkg;

    localparam int STAT_W = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

    function automatic int in_w(input int w);
        return ((w + 7) / 8) * 8;
    endfunction

    function automatic int out_w(input int w);
        return ((w + 8) / 8) * 8;
    endfunction

    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_arb_tag_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adder_arb_tag_fifo                                                         |
// | Synchronous FIFO holding requester IDs of issued, unreturned operations.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module adder_arb_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            // Simultaneous push and pop leave the occupancy unchanged.
            if (push_ok && !pop_ok) begin
                count <= count + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/adder_axis_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adder_axis_arbiter                                                         |
// | Round-robin sharing of one streaming adder among N_REQ requesters; results |
// | are routed back by a tag FIFO. Optional macro: ADDER_ARB_STATS_EN adds     |
// | saturating per-requester completion counters on STAT_CNT.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module adder_axis_arbiter
    import adder_arb_pkg::*;
#(
    parameter int ADDER_WIDTH     = 8,
    parameter int N_REQ           = 4,
    parameter int MAX_OUTSTANDING = 4,
    localparam int IN_W           = in_w(ADDER_WIDTH),
    localparam int OUT_W          = out_w(ADDER_WIDTH),
    localparam int ID_W           = id_w(N_REQ)
) (
    input  logic                      ACLK_I,
    input  logic                      ARST_I,
    input  logic [N_REQ*2*IN_W-1:0]   REQ_TDATA,
    input  logic [N_REQ-1:0]          REQ_TVALID,
    output logic [N_REQ-1:0]          REQ_TREADY,
    output logic [N_REQ*OUT_W-1:0]    RSP_TDATA,
    output logic [N_REQ-1:0]          RSP_TVALID,
    input  logic [N_REQ-1:0]          RSP_TREADY,
    output logic [IN_W-1:0]           OP1_TDATA,
    output logic                      OP1_TVALID,
    input  logic                      OP1_TREADY,
    output logic [IN_W-1:0]           OP2_TDATA,
    output logic                      OP2_TVALID,
    input  logic                      OP2_TREADY,
    input  logic [OUT_W-1:0]          RES_TDATA,
    input  logic                      RES_TVALID,
    output logic                      RES_TREADY,
    output logic [N_REQ*STAT_W-1:0]   STAT_CNT
);

    arb_state_t      state;
    arb_state_t      state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] sel_id;
    logic [ID_W-1:0] head_id;
    logic            sel_found;
    logic [IN_W-1:0] op1_q;
    logic [IN_W-1:0] op2_q;
    logic            sent1;
    logic            sent2;
    logic            grant_fire;
    logic            issue_done;
    logic            op1_fire;
    logic            op2_fire;
    logic            res_fire;
    logic            fifo_full;
    logic            fifo_empty;

    // Scan downward so the last hit is the first valid requester from rr_ptr.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (REQ_TVALID[idx]) begin
                sel_found = 1'b1;
                sel_id    = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge ACLK_I or posedge ARST_I) begin
        if (ARST_I) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        REQ_TREADY = '0;
        OP1_TVALID = 1'b0;
        OP2_TVALID = 1'b0;
        grant_fire = 1'b0;
        issue_done = 1'b0;
        case (state)
            IDLE: begin
                if (sel_found && !fifo_full) begin
                    REQ_TREADY[sel_id] = 1'b1;
                    grant_fire         = 1'b1;
                    state_nxt          = ISSUE;
                end
            end
            ISSUE: begin
                OP1_TVALID = !sent1;
                OP2_TVALID = !sent2;
                if ((sent1 || OP1_TREADY) && (sent2 || OP2_TREADY)) begin
                    issue_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign op1_fire  = OP1_TVALID && OP1_TREADY;
    assign op2_fire  = OP2_TVALID && OP2_TREADY;
    assign OP1_TDATA = op1_q;
    assign OP2_TDATA = op2_q;

    always_ff @(posedge ACLK_I or posedge ARST_I) begin
        if (ARST_I) begin
            rr_ptr   <= '0;
            grant_id <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            sent1    <= 1'b0;
            sent2    <= 1'b0;
        end else if (grant_fire) begin
            op1_q    <= REQ_TDATA[int'(sel_id)*2*IN_W +: IN_W];
            op2_q    <= REQ_TDATA[int'(sel_id)*2*IN_W + IN_W +: IN_W];
            grant_id <= sel_id;
            sent1    <= 1'b0;
            sent2    <= 1'b0;
        end else if (state == ISSUE) begin
            sent1 <= sent1 | op1_fire;
            sent2 <= sent2 | op2_fire;
            if (issue_done) begin
                rr_ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
            end
        end
    end

    adder_arb_tag_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk   (ACLK_I),
        .rst   (ARST_I),
        .push  (grant_fire),
        .pop   (res_fire),
        .din   (sel_id),
        .dout  (head_id),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Results come back in issue order, so the FIFO head names their owner.
    assign RES_TREADY = !fifo_empty && RSP_TREADY[head_id];
    assign res_fire   = RES_TVALID && RES_TREADY;
    assign RSP_TDATA  = {N_REQ{RES_TDATA}};

    always_comb begin
        RSP_TVALID = '0;
        if (RES_TVALID && !fifo_empty) begin
            RSP_TVALID[head_id] = 1'b1;
        end
    end

`ifdef ADDER_ARB_STATS_EN
    for (genvar i = 0; i < N_REQ; i++) begin : g_stat
        logic [STAT_W-1:0] cnt;
        always_ff @(posedge ACLK_I or posedge ARST_I) begin
            if (ARST_I) begin
                cnt <= '0;
            end else if (RSP_TVALID[i] && RSP_TREADY[i] && (cnt != '1)) begin
                cnt <= cnt + STAT_W'(1);
            end
        end
        assign STAT_CNT[i*STAT_W +: STAT_W] = cnt;
    end
`else
    assign STAT_CNT = '0;
`endif

endmodule
`default_nettype wire
